// File: rtl/spike_rate_encoder_pkg.sv
// Shared types and constants for the spike rate encoder: channel geometry, FSM states,
// and the LFSR constants plus helpers used when SPIKE_ENC_LFSR_EN is defined.
package spike_enc_pkg;

  localparam int NUM_CH = 8;
  localparam int RATE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois form: shift right, fold the taps in when a one falls out of bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

  function automatic logic [RATE_W-1:0] rotl8(input logic [RATE_W-1:0] x, input logic [2:0] n);
    logic [2*RATE_W-1:0] d;
    d = {x, x} << n;
    return d[2*RATE_W-1 -: RATE_W];
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Rate register write bus of the spike rate encoder.
interface spike_rate_encoder_if;
  import spike_enc_pkg::*;

  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [RATE_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/spike_rate_encoder_channel.sv
// One encoder channel: rate register, phase accumulator and registered spike bit.
// With SPIKE_ENC_LFSR_EN defined the accumulator is replaced by a compare against a random byte.
module spike_rate_channel
  import spike_enc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              clear,
  input  logic              wr,
  input  logic [RATE_W-1:0] data,
`ifdef SPIKE_ENC_LFSR_EN
  input  logic [RATE_W-1:0] rnd,
`endif
  output logic              spike
);

  logic [RATE_W-1:0] rate_q, rate_d;
  logic              spike_q, spike_d;

  // The tick always sees rate_q, so a write landing on a tick cycle applies from the next tick.
  always_comb begin
    rate_d = wr ? data : rate_q;
  end

`ifdef SPIKE_ENC_LFSR_EN
  always_comb begin
    spike_d = tick && !clear && (rnd < rate_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      spike_q <= spike_d;
    end
  end
`else
  logic [RATE_W-1:0] acc_q, acc_d;
  logic [RATE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, rate_q};
    acc_d   = acc_q;
    spike_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d   = sum[RATE_W-1:0];
      spike_d = sum[RATE_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q  <= '0;
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end
`endif

  assign spike = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Eight-channel rate-to-spike encoder: FSM, tick prescaler, window counter and write decode.
// Define SPIKE_ENC_LFSR_EN for stochastic (LFSR compare) spike generation.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter logic [23:0] TICK_DIV     = 24'd10_000_000,
  parameter logic [15:0] WINDOW_TICKS = 16'd256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  spike_rate_encoder_if.slave  wr,
  output logic [NUM_CH-1:0]    spikes,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  state_e        state_q, state_d;
  logic [23:0]   presc_q, presc_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic          enter_run;
  logic          in_run;
  logic [NUM_CH-1:0] spike_vec;

  always_comb begin
    in_run    = (state_q == RUN);
    enter_run = start && !in_run;
    tick      = in_run && en && (presc_q == TICK_DIV - 24'd1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (tick && (WINDOW_TICKS != 16'd0) && (tick_cnt_q + 16'd1 == WINDOW_TICKS))
          state_d = DONE;
      end
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Prescaler freezes (not clears) while en is low, so a pause resumes mid-period.
  always_comb begin
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    if (enter_run) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if (in_run && en) begin
      presc_d = tick ? 24'd0 : presc_q + 24'd1;
      if (tick) tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

`ifdef SPIKE_ENC_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enter_run) lfsr_d = LFSR_SEED;
    else if (tick) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_rate_channel u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .clear (enter_run),
      .wr    (wr.wr_en && (wr.wr_addr == 3'(i))),
      .data  (wr.wr_data),
`ifdef SPIKE_ENC_LFSR_EN
      .rnd   (rotl8(lfsr_q[RATE_W-1:0], 3'(i))),
`endif
      .spike (spike_vec[i])
    );
  end

  // Pending pulses are masked while paused so the neuron sees nothing with en low.
  always_comb begin
    spikes = spike_vec & {NUM_CH{en}};
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (TICK_DIV=4, WINDOW_TICKS=8) plus a free-running instance.
module tb_spike_rate_encoder;

  logic       clk = 1'b0;
  logic       reset, en, start, start2;
  logic [7:0] spikes, spikes2;
  logic       tick, busy, done, tick2, busy2, done2;

  spike_rate_encoder_if wr_if ();
  spike_rate_encoder_if wr2_if ();

  spike_rate_encoder #(.TICK_DIV(24'd4), .WINDOW_TICKS(16'd8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .wr(wr_if),
    .spikes(spikes), .tick(tick), .busy(busy), .done(done)
  );

  spike_rate_encoder #(.TICK_DIV(24'd4), .WINDOW_TICKS(16'd0)) u_free (
    .clk(clk), .reset(reset), .en(en), .start(start2), .wr(wr2_if),
    .spikes(spikes2), .tick(tick2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  rates   [8] = '{8'd128, 8'd255, 8'd64, 8'd1, 8'd0, 8'd128, 8'd255, 8'd64};
  // Bit k set = pulse following tick k (ticks numbered from 1).
  logic [15:0] exp_msk [8] = '{16'h0154, 16'h01FC, 16'h0110, 16'h0000,
                               16'h0000, 16'h0154, 16'h01FC, 16'h0110};

  task automatic write_rate(input logic [2:0] ch, input logic [7:0] v);
    wr_if.wr_en = 1'b1; wr_if.wr_addr = ch; wr_if.wr_data = v;
    @(posedge clk); #1;
    wr_if.wr_en = 1'b0;
  endtask

  task automatic load_rates();
    for (int c = 0; c < 8; c++) write_rate(3'(c), rates[c]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic watch(input int pause_at, input int wr_at, input int start_at,
                       output logic [15:0] masks [8], output int busy_n,
                       output int orphans, output int gated_bad, output int got_done);
    int   tick_n    = 0;
    logic prev_tick = 1'b0;
    for (int c = 0; c < 8; c++) masks[c] = '0;
    busy_n = 0; orphans = 0; gated_bad = 0; got_done = 0;
    for (int it = 0; it < 200; it++) begin
      if (it == pause_at)      en = 1'b0;
      if (it == pause_at + 10) en = 1'b1;
      wr_if.wr_en = (it == wr_at);
      if (it == wr_at) begin wr_if.wr_addr = 3'd3; wr_if.wr_data = 8'd255; end
      start = (it == start_at);
      #1;
      if (!en && (tick || spikes != 8'd0)) gated_bad++;
      if (busy) busy_n++;
      for (int c = 0; c < 8; c++)
        if (spikes[c]) begin
          if (prev_tick) masks[c][tick_n] = 1'b1;
          else orphans++;
        end
      prev_tick = tick;
      if (tick) tick_n++;
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    wr_if.wr_en = 1'b0;
    start = 1'b0;
    en = 1'b1;
  endtask

  logic [15:0] m [8];
  int bn, orph, gbad, gd;

  initial begin
    reset = 1'b0; en = 1'b1; start = 1'b0; start2 = 1'b0;
    wr_if.wr_en = 1'b0;  wr_if.wr_addr = '0;  wr_if.wr_data = '0;
    wr2_if.wr_en = 1'b0; wr2_if.wr_addr = '0; wr2_if.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spikes", 32'(spikes), 32'h0);
    chk("rst_tick",   32'(tick),   32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_tick", 32'(tick), 32'h0);

    // First window: rate sweep across all channels.
    load_rates();
    do_start();
    watch(-1, -1, -1, m, bn, orph, gbad, gd);
    chk("w1_done", 32'(gd), 32'h1);
    chk("w1_busy_cycles", 32'(bn), 32'd32);
    chk("w1_orphans", 32'(orph), 32'h0);
    for (int c = 0; c < 8; c++) chk($sformatf("w1_mask_ch%0d", c), 32'(m[c]), 32'(exp_msk[c]));
    @(posedge clk); #1;
    chk("w1_done_held", 32'(done), 32'h1);
    chk("w1_busy_low",  32'(busy), 32'h0);

    // Restart from DONE, with a start mid-window that must be ignored.
    do_start();
    watch(-1, -1, 16, m, bn, orph, gbad, gd);
    chk("w2_done", 32'(gd), 32'h1);
    chk("w2_busy_cycles", 32'(bn), 32'd32);
    for (int c = 0; c < 8; c++) chk($sformatf("w2_mask_ch%0d", c), 32'(m[c]), 32'(exp_msk[c]));

    // Pause for 10 cycles mid-window.
    do_start();
    watch(10, -1, -1, m, bn, orph, gbad, gd);
    chk("pause_done", 32'(gd), 32'h1);
    chk("pause_busy_cycles", 32'(bn), 32'd42);
    chk("pause_gated", 32'(gbad), 32'h0);
    chk("pause_orphans", 32'(orph), 32'h0);
    for (int c = 0; c < 8; c++) chk($sformatf("pause_mask_ch%0d", c), 32'(m[c]), 32'(exp_msk[c]));

    // Write/tick collision: rates cleared by reset, ch3 <- 255 on tick 1.
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    do_start();
    watch(-1, 3, -1, m, bn, orph, gbad, gd);
    chk("coll_done", 32'(gd), 32'h1);
    for (int c = 0; c < 8; c++)
      chk($sformatf("coll_mask_ch%0d", c), 32'(m[c]), (c == 3) ? 32'h01F8 : 32'h0);

    // Reset mid-window while pulses are on the outputs.
    load_rates();
    do_start();
    repeat (8) @(posedge clk);
    #1;
    chk("prerst_spikes", 32'(spikes), 32'h63);
    reset = 1'b0; #1;
    chk("midrst_spikes", 32'(spikes), 32'h0);
    chk("midrst_busy",   32'(busy),   32'h0);
    chk("midrst_done",   32'(done),   32'h0);
    chk("midrst_tick",   32'(tick),   32'h0);
    #3; reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_busy", 32'(busy), 32'h0);
    do_start();
    watch(-1, -1, -1, m, bn, orph, gbad, gd);
    chk("postrst_done", 32'(gd), 32'h1);
    for (int c = 0; c < 8; c++) chk($sformatf("postrst_mask_ch%0d", c), 32'(m[c]), 32'h0);

    // Free-running instance: 1000 ticks, done must never rise.
    begin
      int ticks = 0, done_seen = 0, spk = 0;
      wr2_if.wr_en = 1'b1; wr2_if.wr_addr = 3'd0; wr2_if.wr_data = 8'd128;
      @(posedge clk); #1;
      wr2_if.wr_en = 1'b0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int cyc = 0; cyc < 6000 && ticks < 1000; cyc++) begin
        if (done2) done_seen++;
        if (spikes2[0]) spk++;
        if (tick2) ticks++;
        @(posedge clk); #1;
      end
      chk("free_ticks", 32'(ticks), 32'd1000);
      chk("free_done_seen", 32'(done_seen), 32'h0);
      chk("free_busy", 32'(busy2), 32'h1);
      chk("free_spikes", 32'(spk), 32'd499);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Converts eight 8-bit intensity values into eight spike trains that feed a neuron's `inputs[7:0]`. It is the transmit end of the spike interface: the neuron consumes spikes, this block produces them. Spike trains are generated deterministically by per-channel phase accumulators. Generation runs for a programmable window of time-step ticks, then reports done.

Parameters:
- TICK_DIV, 24'd10_000_000, number of clk cycles per time-step tick (min 1).
- WINDOW_TICKS, 16'd256, ticks per encoding window; 0 means free-running, so DONE is never reached.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- en  input  1  global enable; low pauses generation
- start  input  1  one-cycle pulse; begins a window
- wr_en  input  1  rate register write strobe
- wr_addr  input  3  channel index
- wr_data  input  8  rate value (0 = silent, 255 = max)
- spikes  output  8  spike pulses, one bit per channel, to the neuron's inputs
- tick  output  1  one-cycle time-step strobe
- busy  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- Clocking and reset: one clock, `clk`; reset is asynchronous and active-low, port `reset`.
- Reset values:
  - spikes = 0, tick = 0, busy = 0, done = 0.
  - All rate registers, accumulators, prescaler and tick counter = 0.
  - FSM = IDLE.
- FSM transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE on the tick that completes WINDOW_TICKS ticks.
  - DONE → RUN on `start`.
  - `start` while in RUN is ignored.
- Entering RUN (from IDLE or DONE) clears the accumulators, prescaler and tick counter.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN with en = 1.
  - `tick` is combinationally high when count == TICK_DIV-1, RUN and en = 1; the count then wraps to 0.
  - The count is held in IDLE and DONE; it is frozen, not cleared, while en = 0.
- On each tick, for each channel i: sum = {1'b0, acc[i]} + rate[i] (9-bit); acc[i] <= sum[7:0]; spikes[i] <= sum[8].
- Spike timing:
  - spikes are registered and high for exactly 1 clk, in the cycle after the tick (latency 1).
  - spikes = 0 in all other cycles, and whenever en = 0.
- Resulting rates:
  - Spike rate per channel = rate/256 spikes per tick.
  - rate 0 never spikes.
  - rate 255 spikes on every tick except the first of a window.
- Rate writes:
  - Accepted in any state and take effect from the next tick.
  - A write in the same cycle as a tick: the tick uses the old value.
- Window end:
  - The tick counter increments on each tick.
  - When it reaches WINDOW_TICKS (non-zero), the FSM moves to DONE in the cycle after that tick.
  - The final spike pulse still appears in that cycle.
  - busy = 1 exactly in RUN; done = 1 exactly in DONE.
- Reset mid-window returns everything to the reset values immediately. Rate registers are also cleared.

Optional Feature:
- Macro: SPIKE_ENC_LFSR_EN.
- Defined (stochastic, Poisson-like mode):
  - A 16-bit Galois LFSR is used, taps 0xB400, reset/seed 16'hACE1; it is reseeded on entry to RUN and advances once per tick.
  - Channel i spikes when the low byte of the LFSR, rotated left by i, is < rate[i].
  - Accumulators are unused.
  - Timing, window and handshake behaviour are unchanged.
- Undefined: deterministic accumulator mode as above; no LFSR logic is present.

Decomposition:
- Package spike_enc_pkg contains:
  - NUM_CH = 8 and RATE_W = 8.
  - The FSM state enum (IDLE, RUN, DONE).
  - LFSR_SEED and LFSR_TAPS.
- Sub-module spike_rate_channel: one rate register, accumulator and registered spike bit; instantiated NUM_CH times. Inputs: tick, clear, wr strobe, data.
- Top-level spike_rate_encoder holds the FSM, prescaler, tick counter and write decode.

Test Plan:
- Half rate: TICK_DIV = 4, WINDOW_TICKS = 8, rate[0] = 128, start → spikes[0] pulses on ticks 2, 4, 6, 8 (4 pulses), each 1 cycle after tick; done rises after tick 8; busy was high for 32 cycles.
- Rate sweep, same setup: rate 255 → 7 pulses (ticks 2..8); rate 64 → 2 pulses (ticks 4, 8); rate 1 → 0 pulses; rate 0 → 0 pulses. All channels checked independently.
- Write/tick collision: write rate[3] = 255 in the same cycle as tick 1, with old value 0 → no accumulation on tick 1; accumulation with 255 starts from tick 2.
- Pause: drop en for 10 cycles mid-window → tick, spikes and prescaler frozen, spikes = 0; the spike sequence resumes unchanged when en returns.
- Reset mid-window: assert reset during RUN → all outputs 0 immediately, FSM IDLE; a start after release gives no spikes until rates are rewritten.
- Restart and free-run:
  - start in DONE restarts with cleared accumulators; the spike pattern is identical to the first window.
  - With WINDOW_TICKS = 0, done never asserts over 1000 ticks.
  - start in RUN is ignored.
